// File: rtl/step_sequencer.sv
// step_sequencer: initiator side of a step start/done handshake.
// Takes a job (init_data, num_steps) from a host. It drives a single-cycle
// step unit num_steps times and feeds each returned value back in as the
// next operand. The final value is reported with a one-cycle result_valid.
// A step unit that stays silent in WAIT for TIMEOUT cycles ends the job
// with a one-cycle error pulse, and the last good value goes to result.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   req            host job request (sampled only in IDLE)
//   num_steps      step count for the job (sampled with req)
//   init_data      initial operand (sampled with req)
//   busy           high while in ISSUE or WAIT
//   result         final / partial value, held until the next completion
//   result_valid   one-cycle pulse on successful completion
//   error          one-cycle pulse on step timeout
//   step_start     one-cycle start pulse to the step unit
//   step_in_data   operand to the step unit (zero when step_start is low)
//   step_out_data  step unit result, sampled with step_done
//   step_done      step unit completion pulse
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for req; step_done ignored
// ISSUE | one cycle: step_start high, step_in_data = acc, clear timer
// WAIT  | waiting for step_done; timer counts up toward TIMEOUT-1

module step_sequencer #(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [CNT_W-1:0]  num_steps,
  input  logic [DATA_W-1:0] init_data,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              error,
  output logic              step_start,
  output logic [DATA_W-1:0] step_in_data,
  input  logic [DATA_W-1:0] step_out_data,
  input  logic              step_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // TIMEOUT is at most 255, so an 8-bit timer always reaches TIMEOUT-1.
  localparam int             TMR_W    = 8;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic                error_q, error_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      acc_q          <= '0;
      cnt_q          <= '0;
      timer_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      timer_q        <= timer_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      error_q        <= error_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    timer_d        = timer_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    error_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (num_steps != CNT_ZERO) begin
            acc_d   = init_data;
            cnt_d   = num_steps;
            state_d = S_ISSUE;
          end else begin
            // Empty job completes immediately with the initial operand.
            result_d       = init_data;
            result_valid_d = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // step_done is checked first so a late answer on the last
        // timer cycle still counts as a good step.
        if (step_done) begin
          if (cnt_q == CNT_ONE) begin
            result_d       = step_out_data;
            result_valid_d = 1'b1;
            state_d        = S_IDLE;
          end else begin
            acc_d   = step_out_data;
            cnt_d   = cnt_q - 1'b1;
            state_d = S_ISSUE;
          end
        end else if (timer_q == TMR_LAST) begin
          result_d = acc_q;
          error_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All outputs are decoded from registered state only.
  assign busy         = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign step_start   = (state_q == S_ISSUE);
  assign step_in_data = (state_q == S_ISSUE) ? acc_q : '0;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign error        = error_q;

endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic [3:0] num_steps;
  logic [7:0] init_data;
  logic       busy;
  logic [7:0] result;
  logic       result_valid;
  logic       error;
  logic       step_start;
  logic [7:0] step_in_data;
  logic [7:0] step_out_data;
  logic       step_done;

  step_sequencer #(.DATA_W(8), .CNT_W(4), .TIMEOUT(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .num_steps     (num_steps),
    .init_data     (init_data),
    .busy          (busy),
    .result        (result),
    .result_valid  (result_valid),
    .error         (error),
    .step_start    (step_start),
    .step_in_data  (step_in_data),
    .step_out_data (step_out_data),
    .step_done     (step_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Responder control: mute silences the answer to the current start,
  // spur_done forces a step_done pulse regardless of step_start.
  logic mute      = 1'b0;
  logic spur_done = 1'b0;

  // +3 step unit with one-cycle latency: answers in the cycle after step_start.
  initial begin : responder
    logic       ss;
    logic       m;
    logic [7:0] d;
    step_done     = 1'b0;
    step_out_data = 8'h00;
    forever begin
      @(negedge clk);
      ss = step_start;
      d  = step_in_data;
      m  = mute;
      @(posedge clk);
      #1;
      step_done     = (ss && !m) || spur_done;
      step_out_data = d + 8'd3;
    end
  end

  typedef struct {
    logic [7:0] init;
    logic [3:0] num;
    int         silent;      // 1-based step left unanswered, 0 = none
    logic [7:0] exp_result;
    logic       exp_err;
    int         exp_lat;     // edges after E0 until the pulse is visible
    int         exp_busy;
    int         exp_starts;
    bit         spam;        // re-assert req with other data mid-job
    bit         b2b;         // next job requested in the pulse cycle
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v);
    int         k;
    int         starts;
    int         busy_cnt;
    int         consec;
    bit         done;
    bit         got_err;
    bit         prev_ss;
    logic [7:0] exp_in;
    req       = 1'b1;
    init_data = v.init;
    num_steps = v.num;
    mute      = 1'b0;
    tick();  // E0
    req       = 1'b0;
    k = 0; starts = 0; busy_cnt = 0; consec = 0;
    done = 0; got_err = 0; prev_ss = 0;
    exp_in = v.init;
    while (!done && k < 200) begin
      if (result_valid || error) begin
        done    = 1;
        got_err = error;
        check("rv_err_exclusive", {31'd0, result_valid & error}, 32'd0);
      end else begin
        if (busy) busy_cnt++;
        if (step_start) begin
          check("step_in_data", {24'd0, step_in_data}, {24'd0, exp_in});
          exp_in = exp_in + 8'd3;
          if (starts + 1 == v.silent) mute = 1'b1;
          starts++;
          if (prev_ss) consec++;
        end
        if (v.spam && k == 2) begin
          req       = 1'b1;
          init_data = 8'd99;
          num_steps = 4'd1;
        end
        if (v.spam && k == 4) req = 1'b0;
        prev_ss = step_start;
        tick();
        k++;
      end
    end
    check("job_finished", {31'd0, done}, 32'd1);
    check("latency", k, v.exp_lat);
    check("result", {24'd0, result}, {24'd0, v.exp_result});
    check("error_flag", {31'd0, got_err}, {31'd0, v.exp_err});
    check("start_count", starts, v.exp_starts);
    check("busy_cycles", busy_cnt, v.exp_busy);
    check("start_consecutive", consec, 0);
    mute = 1'b0;
    if (!v.b2b) begin
      tick();
      check("pulse_width_rv", {31'd0, result_valid}, 32'd0);
      check("pulse_width_err", {31'd0, error}, 32'd0);
    end
  endtask

  initial begin : main
    vec_t after_rst;
    int   starts;
    int   guard;

    //             init    num  sil res    err   lat bsy st spam b2b
    vecs[0] = '{8'd10,  4'd4,  0, 8'd22,  1'b0,  8,  8, 4,  1'b1, 1'b1};
    vecs[1] = '{8'd250, 4'd2,  0, 8'd0,   1'b0,  4,  4, 2,  1'b0, 1'b0};
    vecs[2] = '{8'h5A,  4'd0,  0, 8'h5A,  1'b0,  0,  0, 0,  1'b0, 1'b0};
    vecs[3] = '{8'd1,   4'd3,  2, 8'd4,   1'b1, 11, 11, 2,  1'b0, 1'b0};
    vecs[4] = '{8'hFF,  4'd15, 0, 8'h2C,  1'b0, 30, 30, 15, 1'b0, 1'b0};
    vecs[5] = '{8'h80,  4'd1,  0, 8'h83,  1'b0,  2,  2, 1,  1'b0, 1'b0};
    after_rst = '{8'd7, 4'd1,  0, 8'd10,  1'b0,  2,  2, 1,  1'b0, 1'b0};

    rst_n     = 1'b0;
    req       = 1'b0;
    num_steps = 4'd0;
    init_data = 8'd0;
    repeat (3) tick();
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_rv",     {31'd0, result_valid}, 32'd0);
    check("rst_err",    {31'd0, error}, 32'd0);
    check("rst_start",  {31'd0, step_start}, 32'd0);
    check("rst_sid",    {24'd0, step_in_data}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_job(vecs[i]);

    // step_done while idle must not disturb anything.
    spur_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_done_busy",  {31'd0, busy}, 32'd0);
      check("idle_done_start", {31'd0, step_start}, 32'd0);
      check("idle_done_rv",    {31'd0, result_valid}, 32'd0);
    end
    spur_done = 1'b0;
    tick();
    check("idle_done_result", {24'd0, result}, 32'h83);

    // Reset while waiting on the second step.
    req       = 1'b1;
    init_data = 8'd1;
    num_steps = 4'd3;
    tick();
    req    = 1'b0;
    starts = 0;
    guard  = 0;
    while (starts < 2 && guard < 20) begin
      if (step_start) begin
        starts++;
        if (starts == 2) mute = 1'b1;
      end
      tick();
      guard++;
    end
    check("rst_mid_reached_step2", starts, 2);
    tick();
    check("rst_mid_in_wait", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("rst_mid_busy",   {31'd0, busy}, 32'd0);
    check("rst_mid_result", {24'd0, result}, 32'd0);
    check("rst_mid_rv",     {31'd0, result_valid}, 32'd0);
    check("rst_mid_err",    {31'd0, error}, 32'd0);
    check("rst_mid_start",  {31'd0, step_start}, 32'd0);
    check("rst_mid_sid",    {24'd0, step_in_data}, 32'd0);
    rst_n = 1'b1;
    mute  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_quiet", {30'd0, result_valid, error}, 32'd0);
    end
    run_job(after_rst);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
